// File: rtl/mips_pkg.sv
// Shared MIPS front-end types and constants: word type, PC increment,
// default reset/NOP words and the next-PC selector encoding.
package mips_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t PC_INC            = 32'd4;
  localparam word_t NOP_INSTR_DEFAULT = 32'h0000_0000;
  localparam word_t RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam word_t ALIGN_MASK        = 32'h0000_0003;

  typedef enum logic [1:0] {
    SEL_INC    = 2'd0,
    SEL_BRANCH = 2'd1,
    SEL_JUMP   = 2'd2,
    SEL_HOLD   = 2'd3
  } next_pc_sel_t;

  // Word-align a fetch target by clearing the two byte-offset bits.
  function automatic word_t align_word(input word_t addr);
    return addr & ~ALIGN_MASK;
  endfunction

endpackage

// File: rtl/next_pc_select.sv
// Combinational next-PC priority mux: branch > jump > stall > sequential.
module next_pc_select
  import mips_pkg::*;
(
  input  word_t        pc_i,
  input  logic         stall_i,
  input  logic         branch_taken_i,
  input  word_t        branch_target_i,
  input  logic         jump_i,
  input  word_t        jump_target_i,
  output next_pc_sel_t sel_o,
  output word_t        next_pc_o,
  output word_t        pc_plus4_o
);

  word_t pc_plus4;

  assign pc_plus4   = pc_i + PC_INC;
  assign pc_plus4_o = pc_plus4;

  // Older branch in EX beats the younger jump in ID; any redirect beats a stall.
  always_comb begin
    sel_o     = SEL_INC;
    next_pc_o = pc_plus4;
    if (branch_taken_i) begin
      sel_o     = SEL_BRANCH;
      next_pc_o = align_word(branch_target_i);
    end else if (jump_i) begin
      sel_o     = SEL_JUMP;
      next_pc_o = align_word(jump_target_i);
    end else if (stall_i) begin
      sel_o     = SEL_HOLD;
      next_pc_o = pc_i;
    end
  end

endmodule

// File: rtl/fetch_pc_stage.sv
// MIPS instruction-fetch stage: PC register plus IF/ID latch with stall/flush.
// Optional build macro FETCH_BRANCH_STATS_EN adds a saturating taken-branch counter.
module fetch_pc_stage
  import mips_pkg::*;
#(
  parameter word_t RESET_PC  = RESET_PC_DEFAULT,
  parameter word_t NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic [31:0] Instruction,
  output logic [31:0] PC,
  output logic [31:0] IFID_PCPlus4,
  output logic [31:0] IFID_Instruction,
`ifdef FETCH_BRANCH_STATS_EN
  output logic [31:0] TakenCount,
`endif
  output logic        IFID_Valid
);

  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("fetch_pc_stage: RESET_PC must be word aligned");
  end

  next_pc_sel_t sel;
  word_t        next_pc;
  word_t        pc_plus4;

  word_t pc_q,    pc_d;
  word_t pp4_q,   pp4_d;
  word_t instr_q, instr_d;
  logic  valid_q, valid_d;

  next_pc_select u_next_pc_select (
    .pc_i            (pc_q),
    .stall_i         (Stall),
    .branch_taken_i  (BranchTaken),
    .branch_target_i (BranchTarget),
    .jump_i          (Jump),
    .jump_target_i   (JumpTarget),
    .sel_o           (sel),
    .next_pc_o       (next_pc),
    .pc_plus4_o      (pc_plus4)
  );

  // Redirects squash IF/ID with a constant NOP so an X fetch word never leaks.
  always_comb begin
    pc_d    = next_pc;
    pp4_d   = pp4_q;
    instr_d = instr_q;
    valid_d = valid_q;
    unique case (sel)
      SEL_INC: begin
        pp4_d   = pc_plus4;
        instr_d = Instruction;
        valid_d = 1'b1;
      end
      SEL_BRANCH, SEL_JUMP: begin
        pp4_d   = '0;
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
      SEL_HOLD: begin
        pp4_d   = pp4_q;
        instr_d = instr_q;
        valid_d = valid_q;
      end
      default: begin
        pp4_d   = pp4_q;
        instr_d = instr_q;
        valid_d = valid_q;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc_q    <= align_word(RESET_PC);
      pp4_q   <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      pp4_q   <= pp4_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign PC               = pc_q;
  assign IFID_PCPlus4     = pp4_q;
  assign IFID_Instruction = instr_q;
  assign IFID_Valid       = valid_q;

`ifdef FETCH_BRANCH_STATS_EN
  word_t taken_cnt_q, taken_cnt_d;

  // Counts every taken branch, stalled or not, and sticks at all-ones.
  always_comb begin
    taken_cnt_d = taken_cnt_q;
    if (BranchTaken && (taken_cnt_q != '1)) begin
      taken_cnt_d = taken_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      taken_cnt_q <= '0;
    end else begin
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign TakenCount = taken_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Scoreboard bench for fetch_pc_stage: directed vectors push the expected
// post-edge state, a monitor pops and compares one entry per clock edge.
module tb_fetch_pc_stage;

  logic        clk = 1'b0;
  logic        rst, stall, br, jmp;
  logic [31:0] bt, jt, instr;
  logic [31:0] pc, pp4, ins;
  logic        valid;
`ifdef FETCH_BRANCH_STATS_EN
  logic [31:0] taken_cnt;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pp4;
    logic [31:0] ins;
    logic        v;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  logic [31:0] model_cnt = '0;

  localparam logic [31:0] I1 = 32'h2008_0005;
  localparam logic [31:0] I2 = 32'h8C09_0000;
  localparam logic [31:0] I3 = 32'h0123_4020;
  localparam logic [31:0] I4 = 32'hAC0A_0004;
  localparam logic [31:0] NOP = 32'h0000_0000;

  always #5 clk = ~clk;

  fetch_pc_stage dut (
    .Clk              (clk),
    .Rst              (rst),
    .Stall            (stall),
    .BranchTaken      (br),
    .BranchTarget     (bt),
    .Jump             (jmp),
    .JumpTarget       (jt),
    .Instruction      (instr),
    .PC               (pc),
    .IFID_PCPlus4     (pp4),
    .IFID_Instruction (ins),
`ifdef FETCH_BRANCH_STATS_EN
    .TakenCount       (taken_cnt),
`endif
    .IFID_Valid       (valid)
  );

  // Apply one vector before the next rising edge and queue the state expected after it.
  task automatic step(input logic r, input logic s, input logic b, input logic [31:0] b_t,
                      input logic j, input logic [31:0] j_t, input logic [31:0] in_w,
                      input logic [31:0] e_pc, input logic [31:0] e_pp4,
                      input logic [31:0] e_ins, input logic e_v);
    exp_t e;
    @(negedge clk);
    rst = r; stall = s; br = b; bt = b_t; jmp = j; jt = j_t; instr = in_w;
    if (r) model_cnt = '0;
    else if (b && model_cnt != 32'hFFFF_FFFF) model_cnt = model_cnt + 32'd1;
    e.pc = e_pc; e.pp4 = e_pp4; e.ins = e_ins; e.v = e_v; e.cnt = model_cnt;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      if (pc !== e.pc) begin
        n_fail++; $display("FAIL pc vec%0d got %h want %h", n_vec, pc, e.pc);
      end
      if (pp4 !== e.pp4) begin
        n_fail++; $display("FAIL pcplus4 vec%0d got %h want %h", n_vec, pp4, e.pp4);
      end
      if (ins !== e.ins) begin
        n_fail++; $display("FAIL instr vec%0d got %h want %h", n_vec, ins, e.ins);
      end
      if (valid !== e.v) begin
        n_fail++; $display("FAIL valid vec%0d got %b want %b", n_vec, valid, e.v);
      end
`ifdef FETCH_BRANCH_STATS_EN
      if (taken_cnt !== e.cnt) begin
        n_fail++; $display("FAIL takencount vec%0d got %h want %h", n_vec, taken_cnt, e.cnt);
      end
`endif
    end
  end

  initial begin
    int guard;
    rst = 1'b1; stall = 1'b0; br = 1'b0; jmp = 1'b0;
    bt = '0; jt = '0; instr = '0;
    //    rst stl br  bt            jmp jt             instr          pc            pp4           ins   v
    step(1, 0, 0, 32'h0,        0, 32'h0,         I1,            32'h0,        32'h0,        NOP,  0);
    step(1, 0, 0, 32'h0,        0, 32'h0,         I1,            32'h0,        32'h0,        NOP,  0);
    step(0, 0, 0, 32'h0,        0, 32'h0,         I1,            32'h4,        32'h4,        I1,   1);
    step(0, 0, 0, 32'h0,        0, 32'h0,         I1,            32'h8,        32'h8,        I1,   1);
    step(0, 0, 0, 32'h0,        0, 32'h0,         I1,            32'hC,        32'hC,        I1,   1);
    step(0, 0, 0, 32'h0,        0, 32'h0,         I1,            32'h10,       32'h10,       I1,   1);
    step(0, 0, 1, 32'h40,       0, 32'h0,         I2,            32'h40,       32'h0,        NOP,  0);
    step(0, 0, 0, 32'h0,        0, 32'h0,         I3,            32'h44,       32'h44,       I3,   1);
    step(0, 0, 1, 32'h80,       1, 32'h200,       I2,            32'h80,       32'h0,        NOP,  0);
    step(0, 0, 0, 32'h0,        0, 32'h0,         I1,            32'h84,       32'h84,       I1,   1);
    step(0, 0, 0, 32'h0,        1, 32'h20,        I2,            32'h20,       32'h0,        NOP,  0);
    step(0, 0, 0, 32'h0,        0, 32'h0,         I4,            32'h24,       32'h24,       I4,   1);
    step(0, 1, 0, 32'h0,        0, 32'h0,         32'hDEAD_BEEF, 32'h24,       32'h24,       I4,   1);
    step(0, 1, 0, 32'h0,        0, 32'h0,         32'hDEAD_BEEF, 32'h24,       32'h24,       I4,   1);
    step(0, 1, 0, 32'h0,        0, 32'h0,         32'hDEAD_BEEF, 32'h24,       32'h24,       I4,   1);
    step(0, 1, 0, 32'h0,        1, 32'h100,       I1,            32'h100,      32'h0,        NOP,  0);
    step(0, 1, 1, 32'h60,       0, 32'h0,         I1,            32'h60,       32'h0,        NOP,  0);
    step(0, 0, 0, 32'h0,        1, 32'hFFFF_FFFC, 32'hxxxx_xxxx, 32'hFFFF_FFFC, 32'h0,       NOP,  0);
    step(0, 0, 0, 32'h0,        0, 32'h0,         I1,            32'h0,        32'h0,        I1,   1);
    step(0, 0, 1, 32'h43,       0, 32'h0,         I2,            32'h40,       32'h0,        NOP,  0);
    step(0, 0, 0, 32'h0,        1, 32'h107,       I2,            32'h104,      32'h0,        NOP,  0);
    step(0, 0, 0, 32'h0,        0, 32'h0,         I3,            32'h108,      32'h108,      I3,   1);
    step(1, 1, 1, 32'h80,       0, 32'h0,         I3,            32'h0,        32'h0,        NOP,  0);
    step(0, 0, 0, 32'h0,        0, 32'h0,         I4,            32'h4,        32'h4,        I4,   1);
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
